// File: rtl/e_mdu_pkg.sv
// MD command encodings shared with the central decoder, plus the default
// multiply/divide latencies used by the E-stage MDU.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      mdu_none  = 4'd0,
      mdu_mult  = 4'd1,
      mdu_multu = 4'd2,
      mdu_div   = 4'd3,
      mdu_divu  = 4'd4,
      mdu_mfhi  = 4'd5,
      mdu_mflo  = 4'd6,
      mdu_mthi  = 4'd7,
      mdu_mtlo  = 4'd8
   } md_type_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // True for the four commands that occupy the unit for several cycles.
   function automatic logic md_is_arith(input logic [3:0] md);
      return (md == mdu_mult) || (md == mdu_multu) ||
             (md == mdu_div)  || (md == mdu_divu);
   endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with HI/LO registers,
// plus the mthi/mtlo/mfhi/mflo accessors.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDType,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Req,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDOut
);

   // Handshake with the D-stage hazard unit: Start is a same-cycle accept of a
   // mult/multu/div/divu (operands captured at this edge); Busy stays high for
   // exactly the op latency afterwards. Commands seen while Busy are dropped, so
   // the hazard unit must hold any MD instruction while (Start || Busy).

   logic [3:0]  cnt;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] p_hi;
   logic [31:0] p_lo;
   logic        p_wr;

   logic        is_arith;
   logic        is_mult;
   logic [3:0]  load_cnt;

   logic [31:0]        res_hi;
   logic [31:0]        res_lo;
   logic               res_wr;
   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               div_ovf;
   logic [31:0]        b_nz;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quot_u;
   logic [31:0]        rem_u;

   assign Busy     = (cnt != 4'd0);
   assign is_arith = md_is_arith(MDType);
   assign is_mult  = (MDType == mdu_mult) || (MDType == mdu_multu);
   assign Start    = is_arith && !Busy && !Req;
   assign load_cnt = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);

   always_comb begin
      a_sx   = {{32{A[31]}}, A};
      b_sx   = {{32{B[31]}}, B};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, A} * {32'd0, B};

      // Divisors are steered away from 0 and from the -2^31/-1 overflow; dividing
      // by 1 in the overflow case yields exactly LO=0x80000000, HI=0.
      div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
      b_nz    = (B == 32'd0) ? 32'd1 : B;
      a_s     = A;
      b_s     = div_ovf ? 32'sd1 : b_nz;
      quot_s  = a_s / b_s;
      rem_s   = a_s % b_s;
      quot_u  = A / b_nz;
      rem_u   = A % b_nz;

      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      case (MDType)
         mdu_mult: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         mdu_multu: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         mdu_div: begin
            res_hi = rem_s;
            res_lo = quot_s;
            res_wr = (B != 32'd0);
         end
         mdu_divu: begin
            res_hi = rem_u;
            res_lo = quot_u;
            res_wr = (B != 32'd0);
         end
         default: res_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= 4'd0;
         hi_q <= 32'd0;
         lo_q <= 32'd0;
         p_hi <= 32'd0;
         p_lo <= 32'd0;
         p_wr <= 1'b0;
      end else if (Start) begin
         cnt  <= load_cnt;
         p_hi <= res_hi;
         p_lo <= res_lo;
         p_wr <= res_wr;
      end else if (Busy) begin
         // A flush (Req) never aborts an op whose instruction already left E.
         cnt <= cnt - 4'd1;
         if ((cnt == 4'd1) && p_wr) begin
            hi_q <= p_hi;
            lo_q <= p_lo;
         end
      end else if (!Req) begin
         if (MDType == mdu_mthi) hi_q <= A;
         if (MDType == mdu_mtlo) lo_q <= A;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

   always_comb begin
      MDOut = 32'd0;
      if (MDType == mdu_mfhi) MDOut = hi_q;
      if (MDType == mdu_mflo) MDOut = lo_q;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops checked
// against a 64-bit arithmetic reference model.
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic        clk;
   logic        reset;
   logic [3:0]  MDType;
   logic [31:0] A;
   logic [31:0] B;
   logic        Req;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDOut;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .MDType (MDType),
      .A      (A),
      .B      (B),
      .Req    (Req),
      .Start  (Start),
      .Busy   (Busy),
      .HI     (HI),
      .LO     (LO),
      .MDOut  (MDOut)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: results from plain 64-bit arithmetic
   function automatic void ref_compute(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic wr,
                                       output logic [31:0] hi, output logic [31:0] lo);
      int sa;
      int sb;
      longint p;
      longint r;
      longint unsigned pu;
      sa = a;
      sb = b;
      wr = 1'b1;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         OP_MULT: begin
            p  = longint'(sa) * longint'(sb);
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULTU: begin
            pu = a;
            pu = pu * b;
            hi = pu[63:32];
            lo = pu[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               p  = longint'(sa) / longint'(sb);
               r  = longint'(sa) % longint'(sb);
               lo = p[31:0];
               hi = r[31:0];
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               lo = a / b;
               hi = a % b;
            end
         end
         default: wr = 1'b0;
      endcase
   endfunction

   function automatic int op_cycles(input logic [3:0] op);
      return (op == OP_MULT || op == OP_MULTU) ? MC : DC;
   endfunction

   // driver tasks
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] busy_md, input logic [31:0] busy_a,
                         input logic busy_req, output logic started, output int busy_n);
      MDType = op;
      A      = a;
      B      = b;
      Req    = 1'b0;
      #1;
      started = Start;
      tick();
      MDType = busy_md;
      A      = busy_a;
      Req    = busy_req;
      busy_n = 0;
      while (Busy && busy_n < 40) begin
         B = $urandom;
         busy_n++;
         tick();
      end
      MDType = OP_NONE;
      Req    = 1'b0;
      A      = $urandom;
      B      = $urandom;
   endtask

   task automatic do_mt(input logic [3:0] op, input logic [31:0] val);
      MDType = op;
      A      = val;
      tick();
      MDType = OP_NONE;
      A      = $urandom;
      if (op == OP_MTHI) m_hi = val;
      if (op == OP_MTLO) m_lo = val;
   endtask

   // tests
   task automatic test_reset();
      reset  = 1'b1;
      MDType = OP_NONE;
      tick();
      tick();
      n_checks++;
      if (Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
      n_checks++;
      if (Start !== 1'b0) begin n_errors++; $display("FAIL reset_start got %b exp 0", Start); end
      n_checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin
         n_errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", HI, LO);
      end
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      tick();
   endtask

   task automatic test_mult_directed();
      logic st;
      int   n;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, OP_NONE, $urandom, 1'b0, st, n);
      n_checks++;
      if (st !== 1'b1) begin n_errors++; $display("FAIL mult_start got %b exp 1", st); end
      n_checks++;
      if (n != MC) begin n_errors++; $display("FAIL mult_busy got %0d exp %0d", n, MC); end
      n_checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
         n_errors++; $display("FAIL mult_hilo got %h/%h exp ffffffff/fffffff1", HI, LO);
      end
      MDType = OP_MFLO;
      #1;
      n_checks++;
      if (MDOut !== 32'hFFFF_FFF1) begin n_errors++; $display("FAIL mflo got %h exp fffffff1", MDOut); end
      MDType = OP_MFHI;
      #1;
      n_checks++;
      if (MDOut !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mfhi got %h exp ffffffff", MDOut); end
      MDType = OP_NONE;
      m_hi = 32'hFFFF_FFFF;
      m_lo = 32'hFFFF_FFF1;
      tick();
   endtask

   task automatic test_multu_operand_capture();
      logic st;
      int   n;
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, OP_NONE, 32'h1234_5678, 1'b0, st, n);
      n_checks++;
      if (st !== 1'b1 || n != MC) begin
         n_errors++; $display("FAIL multu_timing got start=%b busy=%0d exp 1/%0d", st, n, MC);
      end
      n_checks++;
      if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
         n_errors++; $display("FAIL multu_hilo got %h/%h exp 00000001/fffffffe", HI, LO);
      end
      m_hi = 32'h0000_0001;
      m_lo = 32'hFFFF_FFFE;
   endtask

   task automatic test_div_directed();
      logic st;
      int   n;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, OP_NONE, $urandom, 1'b0, st, n);
      n_checks++;
      if (st !== 1'b1 || n != DC) begin
         n_errors++; $display("FAIL div_timing got start=%b busy=%0d exp 1/%0d", st, n, DC);
      end
      n_checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
         n_errors++; $display("FAIL div_hilo got %h/%h exp ffffffff/fffffffd", HI, LO);
      end
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, OP_NONE, $urandom, 1'b0, st, n);
      n_checks++;
      if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
         n_errors++; $display("FAIL div_ovf got %h/%h exp 00000000/80000000", HI, LO);
      end
      m_hi = 32'd0;
      m_lo = 32'h8000_0000;
   endtask

   task automatic test_div_zero();
      logic st;
      int   n;
      do_mt(OP_MTHI, 32'h11);
      do_mt(OP_MTLO, 32'h22);
      n_checks++;
      if (HI !== 32'h11 || LO !== 32'h22) begin
         n_errors++; $display("FAIL mthi_mtlo got %h/%h exp 00000011/00000022", HI, LO);
      end
      run_op(OP_DIVU, 32'd7, 32'd0, OP_NONE, $urandom, 1'b0, st, n);
      n_checks++;
      if (st !== 1'b1 || n != DC) begin
         n_errors++; $display("FAIL divz_timing got start=%b busy=%0d exp 1/%0d", st, n, DC);
      end
      n_checks++;
      if (HI !== 32'h11 || LO !== 32'h22) begin
         n_errors++; $display("FAIL divz_hilo got %h/%h exp 00000011/00000022", HI, LO);
      end
   endtask

   task automatic test_req();
      logic        st;
      int          n;
      logic        wr;
      logic [31:0] eh;
      logic [31:0] el;
      logic [31:0] a;
      logic [31:0] b;
      MDType = OP_DIV;
      A      = 32'd100;
      B      = 32'd7;
      Req    = 1'b1;
      #1;
      n_checks++;
      if (Start !== 1'b0) begin n_errors++; $display("FAIL req_start got %b exp 0", Start); end
      tick();
      MDType = OP_MTHI;
      A      = 32'hBAD0_BAD0;
      tick();
      MDType = OP_NONE;
      Req    = 1'b0;
      n_checks++;
      if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
         n_errors++; $display("FAIL req_flush got busy=%b %h/%h exp 0 %h/%h", Busy, HI, LO, m_hi, m_lo);
      end
      a = $urandom;
      b = $urandom;
      ref_compute(OP_MULT, a, b, wr, eh, el);
      run_op(OP_MULT, a, b, OP_NONE, $urandom, 1'b1, st, n);
      n_checks++;
      if (n != MC || HI !== eh || LO !== el) begin
         n_errors++; $display("FAIL req_during got busy=%0d %h/%h exp %0d %h/%h", n, HI, LO, MC, eh, el);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic test_reset_mid_op();
      MDType = OP_MULT;
      A      = 32'h0001_0000;
      B      = 32'h0003_0000;
      tick();
      MDType = OP_NONE;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      n_checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         n_errors++; $display("FAIL reset_mid got busy=%b %h/%h exp 0 0/0", Busy, HI, LO);
      end
      repeat (12) tick();
      n_checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin
         n_errors++; $display("FAIL reset_mid_late got %h/%h exp 0/0", HI, LO);
      end
   endtask

   task automatic test_back_to_back();
      logic        st;
      int          n;
      logic        wr;
      logic [31:0] eh;
      logic [31:0] el;
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      ref_compute(OP_MULT, a, b, wr, eh, el);
      run_op(OP_MULT, a, b, OP_MULT, $urandom, 1'b0, st, n);
      n_checks++;
      if (n != MC) begin n_errors++; $display("FAIL b2b_busy got %0d exp %0d", n, MC); end
      n_checks++;
      if (HI !== eh || LO !== el) begin
         n_errors++; $display("FAIL b2b_hilo got %h/%h exp %h/%h", HI, LO, eh, el);
      end
      a = $urandom;
      b = $urandom_range(1, 1000);
      ref_compute(OP_MULTU, a, b, wr, eh, el);
      run_op(OP_MULTU, a, b, OP_MTHI, 32'h0000_DEAD, 1'b0, st, n);
      n_checks++;
      if (st !== 1'b1 || HI !== eh || LO !== el || HI === 32'h0000_DEAD) begin
         n_errors++; $display("FAIL mthi_busy got %h/%h exp %h/%h", HI, LO, eh, el);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic test_unused_codes();
      for (int c = 9; c <= 15; c++) begin
         MDType = 4'(c);
         A      = $urandom;
         #1;
         n_checks++;
         if (Start !== 1'b0 || MDOut !== 32'd0) begin
            n_errors++; $display("FAIL unused_%0d got start=%b mdout=%h exp 0/0", c, Start, MDOut);
         end
         tick();
         n_checks++;
         if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            n_errors++; $display("FAIL unused_state_%0d got %h/%h exp %h/%h", c, HI, LO, m_hi, m_lo);
         end
      end
      MDType = OP_NONE;
   endtask

   task automatic test_random_ops();
      logic        st;
      int          n;
      logic        wr;
      logic [31:0] eh;
      logic [31:0] el;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(1, 4));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 9);
            3: a = $urandom_range(0, 50);
            default: ;
         endcase
         ref_compute(op, a, b, wr, eh, el);
         if (wr) begin
            m_hi = eh;
            m_lo = el;
         end
         run_op(op, a, b, OP_NONE, $urandom, 1'($urandom_range(0, 1)), st, n);
         n_checks++;
         if (st !== 1'b1 || n != op_cycles(op)) begin
            n_errors++;
            $display("FAIL rand_timing op=%0d got start=%b busy=%0d exp 1/%0d", op, st, n, op_cycles(op));
         end
         n_checks++;
         if (HI !== m_hi || LO !== m_lo) begin
            n_errors++;
            $display("FAIL rand_hilo op=%0d a=%h b=%h got %h/%h exp %h/%h", op, a, b, HI, LO, m_hi, m_lo);
         end
         MDType = OP_MFHI;
         #1;
         n_checks++;
         if (MDOut !== m_hi) begin n_errors++; $display("FAIL rand_mfhi got %h exp %h", MDOut, m_hi); end
         MDType = OP_MFLO;
         #1;
         n_checks++;
         if (MDOut !== m_lo) begin n_errors++; $display("FAIL rand_mflo got %h exp %h", MDOut, m_lo); end
         MDType = OP_NONE;
      end
   endtask

   initial begin
      reset  = 1'b1;
      MDType = OP_NONE;
      A      = 32'd0;
      B      = 32'd0;
      Req    = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      test_reset();
      test_mult_directed();
      test_multu_operand_capture();
      test_div_directed();
      test_div_zero();
      test_req();
      test_reset_mid_op();
      test_back_to_back();
      test_unused_codes();
      test_random_ops();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
